// File: rtl/online_softmax_acc_pkg.sv
// Shared types and constants for the online softmax accumulator.
// SEQ_LEN defaults to `MAX_SEQ_LENGTH, which falls back to 4 when not supplied by the build.
`ifndef MAX_SEQ_LENGTH
`define MAX_SEQ_LENGTH 4
`endif

package online_softmax_acc_pkg;

    localparam int DK        = 64;
    localparam int FRAC_BITS = 3;
    localparam int ACC_W     = 24;
    localparam int EXP_ONE   = 256;

    typedef logic signed [15:0]      INT_T;
    typedef logic signed [7:0]       V_ELEM_T;
    typedef V_ELEM_T [DK-1:0]        V_VECTOR_T;
    typedef V_ELEM_T [DK-1:0]        O_VECTOR_T;
    typedef logic [8:0]              EXP_T;
    typedef logic signed [ACC_W-1:0] ACC_T;
    typedef logic [15:0]             L_T;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_NORM  = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

endpackage

// File: rtl/online_softmax_acc_exp_lut.sv
// exp(-d * 2^-3) lookup, scaled so that 256 = 1.0; input index is the clamped score difference.
module online_softmax_acc_exp_lut
    import online_softmax_acc_pkg::*;
(
    input  logic [7:0] i_idx,
    output EXP_T       o_exp
);

    // Entries 50 and up round to zero, so only the low 64 are stored.
    localparam EXP_T LUT [64] = '{
        EXP_T'(EXP_ONE), 9'd226, 9'd199, 9'd176, 9'd155, 9'd137, 9'd121, 9'd107,
        9'd94,  9'd83,  9'd73,  9'd65,  9'd57,  9'd50,  9'd44,  9'd39,
        9'd35,  9'd31,  9'd27,  9'd24,  9'd21,  9'd19,  9'd16,  9'd14,
        9'd13,  9'd11,  9'd10,  9'd9,   9'd8,   9'd7,   9'd6,   9'd5,
        9'd5,   9'd4,   9'd4,   9'd3,   9'd3,   9'd3,   9'd2,   9'd2,
        9'd2,   9'd2,   9'd1,   9'd1,   9'd1,   9'd1,   9'd1,   9'd1,
        9'd1,   9'd1,   9'd0,   9'd0,   9'd0,   9'd0,   9'd0,   9'd0,
        9'd0,   9'd0,   9'd0,   9'd0,   9'd0,   9'd0,   9'd0,   9'd0
    };

    assign o_exp = (i_idx[7:6] == 2'b00) ? LUT[i_idx[5:0]] : '0;

endmodule

// File: rtl/online_softmax_acc.sv
// Online softmax accumulator: running max/denominator/rescaled O per row, then element-serial divide.
// Optional ONLINE_SOFTMAX_ROUND_EN: round-half-up alpha rescale, round-half-away-from-zero divide.
module online_softmax_acc
    import online_softmax_acc_pkg::*;
#(
    parameter int SEQ_LEN = `MAX_SEQ_LENGTH
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      vld_in,
    output logic      rdy_out,
    input  INT_T      s_in,
    input  V_VECTOR_T v_in,
    output logic      vld_out,
    input  logic      rdy_in,
    output O_VECTOR_T o_out
);

    localparam int BCW = $clog2(SEQ_LEN + 1);
    localparam int IW  = $clog2(DK);
    localparam int PW  = ACC_W + 10;

    typedef logic signed [PW-1:0]  prod_t;
    typedef logic signed [ACC_W:0] div_t;

`ifdef ONLINE_SOFTMAX_ROUND_EN
    localparam int RND = 128;
`else
    localparam int RND = 0;
`endif

    state_t         r_state;
    state_t         w_state_next;
    logic [BCW-1:0] r_beat_cnt;
    logic [IW-1:0]  r_elem_idx;
    INT_T           r_m;
    L_T             r_l;
    ACC_T           r_o_acc [DK];
    O_VECTOR_T      r_o_out;

    logic           w_accept;
    logic           w_first;
    logic           w_last;
    INT_T           w_m_new;
    logic [16:0]    w_da;
    logic [16:0]    w_dp;
    EXP_T           w_alpha_lut;
    EXP_T           w_alpha;
    EXP_T           w_p;
    L_T             w_l_next;
    ACC_T           w_o_next [DK];
    V_ELEM_T        w_q;

    function automatic logic [7:0] f_lut_idx(input logic [16:0] d);
        return (d > 17'd255) ? 8'hFF : d[7:0];
    endfunction

    function automatic V_ELEM_T f_sat8(input div_t q);
        if (q > div_t'(127))  return V_ELEM_T'(127);
        if (q < div_t'(-128)) return V_ELEM_T'(-128);
        return V_ELEM_T'(q);
    endfunction

    function automatic div_t f_div(input ACC_T num, input L_T den);
        div_t n;
        div_t d;
`ifdef ONLINE_SOFTMAX_ROUND_EN
        div_t mag;
`endif
        n = div_t'(num);
        d = div_t'(den);
`ifdef ONLINE_SOFTMAX_ROUND_EN
        mag = (n < 0) ? -n : n;
        mag = (mag + (d >>> 1)) / d;
        return (n < 0) ? -mag : mag;
`else
        return n / d;
`endif
    endfunction

    assign w_accept = vld_in && rdy_out;
    assign w_first  = (r_beat_cnt == '0);
    assign w_last   = (r_beat_cnt == BCW'(SEQ_LEN - 1));
    // First beat of a row forces m_new=s and alpha=0, so stale m/l/O drop out of the shared datapath.
    assign w_m_new  = (w_first || (s_in > r_m)) ? s_in : r_m;
    assign w_da     = {w_m_new[15], w_m_new} - {r_m[15], r_m};
    assign w_dp     = {w_m_new[15], w_m_new} - {s_in[15], s_in};
    assign w_alpha  = w_first ? '0 : w_alpha_lut;

    online_softmax_acc_exp_lut u_exp_alpha (
        .i_idx (f_lut_idx(w_da)),
        .o_exp (w_alpha_lut)
    );

    online_softmax_acc_exp_lut u_exp_p (
        .i_idx (f_lut_idx(w_dp)),
        .o_exp (w_p)
    );

    assign w_l_next = L_T'(((32'(r_l) * 32'(w_alpha)) + 32'(RND)) >> 8) + L_T'(w_p);

    always_comb begin
        for (int i = 0; i < DK; i++) begin
            w_o_next[i] = ACC_T'((prod_t'(r_o_acc[i]) * prod_t'(w_alpha) + prod_t'(RND)) >>> 8)
                        + ACC_T'(prod_t'($signed(v_in[i])) * prod_t'(w_p));
        end
    end

    assign w_q   = f_sat8(f_div(r_o_acc[r_elem_idx], r_l));
    assign o_out = r_o_out;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_ACCUM;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        rdy_out      = 1'b0;
        vld_out      = 1'b0;
        case (r_state)
            ST_ACCUM: begin
                rdy_out = 1'b1;
                if (vld_in && w_last) w_state_next = ST_NORM;
            end
            ST_NORM: begin
                if (r_elem_idx == IW'(DK - 1)) w_state_next = ST_OUT;
            end
            ST_OUT: begin
                vld_out = 1'b1;
                if (rdy_in) w_state_next = ST_ACCUM;
            end
            default: w_state_next = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_beat_cnt <= '0;
            r_elem_idx <= '0;
            r_m        <= '0;
            r_l        <= '0;
            r_o_acc    <= '{default: '0};
            r_o_out    <= '0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        r_m        <= w_m_new;
                        r_l        <= w_l_next;
                        r_o_acc    <= w_o_next;
                        r_beat_cnt <= w_last ? '0 : r_beat_cnt + 1'b1;
                    end
                end
                ST_NORM: begin
                    r_o_out[r_elem_idx] <= w_q;
                    r_elem_idx <= (r_elem_idx == IW'(DK - 1)) ? '0 : r_elem_idx + 1'b1;
                end
                ST_OUT: begin
                    if (rdy_in) begin
                        r_beat_cnt <= '0;
                        r_m        <= '0;
                        r_l        <= '0;
                        r_o_acc    <= '{default: '0};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_online_softmax_acc.sv
// Bench for online_softmax_acc (SEQ_LEN=4): directed and random rows checked against a queued reference model.
module tb_online_softmax_acc;
    import online_softmax_acc_pkg::*;

    localparam int SEQ = 4;
    localparam int LAT = DK + 1;
`ifdef ONLINE_SOFTMAX_ROUND_EN
    localparam longint RND     = 128;
    localparam int     ORD_EXP = 47;
`else
    localparam longint RND     = 0;
    localparam int     ORD_EXP = 46;
`endif

    logic      clk;
    logic      rst;
    logic      vld_in;
    logic      rdy_out;
    INT_T      s_in;
    V_VECTOR_T v_in;
    logic      vld_out;
    logic      rdy_in;
    O_VECTOR_T o_out;

    int        total = 0;
    int        bad   = 0;
    O_VECTOR_T exp_q [$];
    int        s_tab [SEQ];
    int        v_tab [SEQ][DK];

    online_softmax_acc #(.SEQ_LEN(SEQ)) dut (
        .clk     (clk),
        .rst     (rst),
        .vld_in  (vld_in),
        .rdy_out (rdy_out),
        .s_in    (s_in),
        .v_in    (v_in),
        .vld_out (vld_out),
        .rdy_in  (rdy_in),
        .o_out   (o_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic longint exp_ref(input longint d);
        longint dc;
        dc = (d > 255) ? 255 : d;
        return longint'(256.0 * $exp(-real'(dc) / real'(1 << FRAC_BITS)));
    endfunction

    task automatic model_push();
        longint    m, l, a, p, mn, q, mag;
        longint    o [DK];
        O_VECTOR_T e;
        m = s_tab[0];
        l = 256;
        for (int i = 0; i < DK; i++) o[i] = 256 * v_tab[0][i];
        for (int b = 1; b < SEQ; b++) begin
            mn = (s_tab[b] > m) ? s_tab[b] : m;
            a  = exp_ref(mn - m);
            p  = exp_ref(mn - s_tab[b]);
            l  = ((l * a + RND) >> 8) + p;
            for (int i = 0; i < DK; i++) o[i] = ((o[i] * a + RND) >>> 8) + p * v_tab[b][i];
            m = mn;
        end
        for (int i = 0; i < DK; i++) begin
`ifdef ONLINE_SOFTMAX_ROUND_EN
            mag = (o[i] < 0) ? -o[i] : o[i];
            q   = (mag + l / 2) / l;
            if (o[i] < 0) q = -q;
`else
            mag = 0;
            q   = o[i] / l;
`endif
            if (q > 127)  q = 127;
            if (q < -128) q = -128;
            e[i] = 8'(q);
        end
        exp_q.push_back(e);
    endtask

    task automatic fill_row(input int s0, input int s1, input int s2, input int s3,
                            input int v0, input int v1, input int v2, input int v3);
        s_tab[0] = s0; s_tab[1] = s1; s_tab[2] = s2; s_tab[3] = s3;
        for (int i = 0; i < DK; i++) begin
            v_tab[0][i] = v0; v_tab[1][i] = v1; v_tab[2][i] = v2; v_tab[3][i] = v3;
        end
    endtask

    task automatic fill_random(input int srange);
        for (int b = 0; b < SEQ; b++) begin
            s_tab[b] = int'($urandom_range(2 * srange)) - srange;
            for (int i = 0; i < DK; i++) v_tab[b][i] = int'($urandom_range(255)) - 128;
        end
    endtask

    task automatic drive_beat(input int b);
        @(negedge clk);
        vld_in = 1'b1;
        s_in   = INT_T'(s_tab[b]);
        for (int i = 0; i < DK; i++) v_in[i] = 8'(v_tab[b][i]);
    endtask

    task automatic send_row();
        for (int b = 0; b < SEQ; b++) drive_beat(b);
        model_push();
        @(posedge clk);
        #1;
        vld_in = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (vld_out !== 1'b1 && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic pop_exp(output O_VECTOR_T e);
        if (exp_q.size() == 0) e = 'x;
        else e = exp_q.pop_front();
    endtask

    task automatic handshake();
        @(negedge clk);
        rdy_in = 1'b1;
        @(posedge clk);
        #1;
        rdy_in = 1'b0;
    endtask

    function automatic O_VECTOR_T splat(input int val);
        O_VECTOR_T r;
        for (int i = 0; i < DK; i++) r[i] = 8'(val);
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1; vld_in = 1'b0; rdy_in = 1'b0; s_in = '0; v_in = '0;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (vld_out !== 1'b0) begin bad++; $display("FAIL reset_vld_out: got %b want 0", vld_out); end
        total++; if (rdy_out !== 1'b1) begin bad++; $display("FAIL reset_rdy_out: got %b want 1", rdy_out); end
        total++; if (o_out !== '0) begin bad++; $display("FAIL reset_o_out: got %h want 0", o_out); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_equal_scores();
        int lat;
        O_VECTOR_T e;
        fill_row(0, 0, 0, 0, 10, 10, 10, 10);
        send_row();
        wait_out(lat);
        total++; if (lat != LAT) begin bad++; $display("FAIL equal_latency: got %0d want %0d", lat, LAT); end
        pop_exp(e);
        total++; if (o_out !== e) begin bad++; $display("FAIL equal_model: got %h want %h", o_out, e); end
        total++; if (o_out !== splat(10)) begin bad++; $display("FAIL equal_const: got %h want all 0a", o_out); end
        handshake();
        total++; if (rdy_out !== 1'b1) begin bad++; $display("FAIL equal_rdy_after: got %b want 1", rdy_out); end
    endtask

    task automatic test_dominant();
        int lat;
        O_VECTOR_T e;
        fill_row(0, 0, 0, 80, 0, 0, 0, 100);
        send_row();
        wait_out(lat);
        pop_exp(e);
        total++; if (o_out !== e) begin bad++; $display("FAIL dominant_model: got %h want %h", o_out, e); end
        total++; if (o_out !== splat(100)) begin bad++; $display("FAIL dominant_const: got %h want all 64", o_out); end
        handshake();
    endtask

    task automatic test_order_independence();
        int lat;
        O_VECTOR_T e, first;
        for (int sg = 0; sg < 2; sg++) begin
            fill_row(8, 0, -400, -400, sg ? -64 : 64, 0, 0, 0);
            send_row();
            wait_out(lat);
            pop_exp(e);
            first = o_out;
            total++; if (o_out !== e) begin bad++; $display("FAIL order_fwd_model: got %h want %h", o_out, e); end
            total++; if (o_out !== splat(sg ? -ORD_EXP : ORD_EXP)) begin
                bad++; $display("FAIL order_fwd_const: got %h want all %0d", o_out, sg ? -ORD_EXP : ORD_EXP);
            end
            handshake();
            fill_row(-400, -400, 0, 8, 0, 0, 0, sg ? -64 : 64);
            send_row();
            wait_out(lat);
            pop_exp(e);
            total++; if (o_out !== e) begin bad++; $display("FAIL order_rev_model: got %h want %h", o_out, e); end
            total++; if (o_out !== first) begin bad++; $display("FAIL order_match: got %h want %h", o_out, first); end
            handshake();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit stable;
        O_VECTOR_T e, cap;
        fill_random(40);
        send_row();
        wait_out(lat);
        cap = o_out;
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            vld_in = 1'b1;
            s_in   = INT_T'(k * 37);
            v_in   = {DK{8'h7f}};
            if (vld_out !== 1'b1 || rdy_out !== 1'b0 || o_out !== cap) stable = 1'b0;
        end
        @(negedge clk);
        vld_in = 1'b0;
        total++; if (!stable) begin bad++; $display("FAIL bp_hold: got unstable want held vld_out=1 rdy_out=0"); end
        pop_exp(e);
        total++; if (cap !== e) begin bad++; $display("FAIL bp_model: got %h want %h", cap, e); end
        handshake();
        total++; if (rdy_out !== 1'b1) begin bad++; $display("FAIL bp_rdy_after: got %b want 1", rdy_out); end
        total++; if (vld_out !== 1'b0) begin bad++; $display("FAIL bp_vld_after: got %b want 0", vld_out); end
    endtask

    task automatic test_back_to_back();
        int lat;
        O_VECTOR_T e;
        for (int r = 0; r < 5; r++) begin
            fill_random(r == 4 ? 1500 : 60);
            send_row();
            wait_out(lat);
            total++; if (lat != LAT) begin bad++; $display("FAIL b2b_latency: got %0d want %0d", lat, LAT); end
            pop_exp(e);
            total++; if (o_out !== e) begin bad++; $display("FAIL b2b_row%0d: got %h want %h", r, o_out, e); end
            handshake();
        end
    endtask

    task automatic test_async_reset();
        int lat;
        O_VECTOR_T e;
        fill_row(40, -20, 0, 0, -100, 90, 0, 0);
        drive_beat(0);
        drive_beat(1);
        @(posedge clk);
        #3;
        vld_in = 1'b0;
        rst = 1'b0;
        #1;
        total++; if (vld_out !== 1'b0) begin bad++; $display("FAIL arst_vld_out: got %b want 0", vld_out); end
        total++; if (rdy_out !== 1'b1) begin bad++; $display("FAIL arst_rdy_out: got %b want 1", rdy_out); end
        total++; if (o_out !== '0) begin bad++; $display("FAIL arst_o_out: got %h want 0", o_out); end
        @(negedge clk);
        rst = 1'b1;
        fill_row(0, 0, 0, 0, 5, 5, 5, 5);
        send_row();
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        total++; if (rdy_out !== 1'b1) begin bad++; $display("FAIL arst_norm_rdy: got %b want 1", rdy_out); end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        send_row();
        wait_out(lat);
        total++; if (lat != LAT) begin bad++; $display("FAIL arst_latency: got %0d want %0d", lat, LAT); end
        pop_exp(e);
        total++; if (o_out !== e) begin bad++; $display("FAIL arst_model: got %h want %h", o_out, e); end
        total++; if (o_out !== splat(5)) begin bad++; $display("FAIL arst_const: got %h want all 05", o_out); end
        handshake();
    endtask

    initial begin
        test_reset();
        test_equal_scores();
        test_dominant();
        test_order_independence();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
